// File: rtl/mag_pkg.sv
// Shared definitions for the successive-approximation magnitude search engine.
//  - CMP_* : 2-bit compare codes produced by the external magnitude comparator
//            for the pair (a = target, b = guess).
//  - state_t : search FSM states.
package mag_pkg;

  localparam logic [1:0] CMP_EQ  = 2'b00;
  localparam logic [1:0] CMP_LT  = 2'b01;
  localparam logic [1:0] CMP_GT  = 2'b10;
  localparam logic [1:0] CMP_BAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_t;

endpackage

// File: rtl/mag_search_sar.sv
// Binary-search (successive-approximation) engine. It drives the b operand of
// an external magnitude comparator with a guess and narrows a [lo, hi] window
// from the returned compare code until the unknown a operand is matched or
// the window is exhausted.
// Ports:
//  clk    - rising-edge clock
//  rst    - synchronous, active-high reset
//  start  - request a new search (only honoured in IDLE)
//  cmp_f  - comparator code for (a=target, b=guess): 00 eq, 01 a<b, 10 a>b, 11 illegal
//  guess  - current b operand driven to the comparator
//  busy   - high while searching
//  done   - one-cycle pulse when a search ends
//  found  - target matched (valid from done onward)
//  err    - illegal compare code seen (valid from done onward)
//  result - matched value (valid when found)
//  steps  - number of compares consumed by the last search
module mag_search_sar
  import mag_pkg::*;
#(
  parameter  int WIDTH  = 4,
  localparam int STEP_W = $clog2(WIDTH + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cmp_f,
  output logic [WIDTH-1:0]  guess,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic              err,
  output logic [WIDTH-1:0]  result,
  output logic [STEP_W-1:0] steps
);

  localparam logic [WIDTH-1:0] GUESS_MAX = '1;
  localparam logic [WIDTH-1:0] GUESS_MID = GUESS_MAX >> 1;
  localparam logic [WIDTH:0]   HI_INIT   = {1'b0, GUESS_MAX};

  state_t              state_q, state_d;
  logic [WIDTH:0]      lo_q, lo_d;
  logic [WIDTH:0]      hi_q, hi_d;
  logic [WIDTH-1:0]    guess_q, guess_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic                found_q, found_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Window arithmetic is one bit wider than the operand so that guess+1 at the
  // top of the range and the lo+hi sum never wrap.
  logic [WIDTH:0] guess_ext;
  logic [WIDTH:0] lo_new, hi_new;
  logic [WIDTH:0] sum_gt, sum_lt;

  always_comb begin
    guess_ext = {1'b0, guess_q};
    lo_new    = guess_ext + 1'b1;
    hi_new    = guess_ext - 1'b1;
    sum_gt    = lo_new + hi_q;
    sum_lt    = lo_q + hi_new;

    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    result_d = result_q;
    steps_d  = steps_q;
    found_d  = found_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lo_d    = '0;
          hi_d    = HI_INIT;
          guess_d = GUESS_MID;
          steps_d = '0;
          found_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_SEARCH;
        end
      end

      S_SEARCH: begin
        steps_d = steps_q + 1'b1;
        case (cmp_f)
          CMP_EQ: begin
            result_d = guess_q;
            found_d  = 1'b1;
            state_d  = S_DONE;
          end
          CMP_GT: begin
            // Target is above the guess; give up if nothing is left above it.
            if (guess_q == GUESS_MAX || lo_new > hi_q) begin
              state_d = S_DONE;
            end else begin
              lo_d    = lo_new;
              guess_d = WIDTH'(sum_gt >> 1);
            end
          end
          CMP_LT: begin
            // Target is below the guess; guess==0 would underflow hi.
            if (guess_q == '0 || lo_q > hi_new) begin
              state_d = S_DONE;
            end else begin
              hi_d    = hi_new;
              guess_d = WIDTH'(sum_lt >> 1);
            end
          end
          default: begin
            err_d   = 1'b1;
            found_d = 1'b0;
            state_d = S_DONE;
          end
        endcase
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered copies of the upcoming state.
    busy_d = (state_d == S_SEARCH);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= HI_INIT;
      guess_q  <= '0;
      result_q <= '0;
      steps_q  <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      found_q  <= found_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign guess  = guess_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;
  assign steps  = steps_q;

endmodule

// File: tb/tb_mag_search_sar.sv
// Self-checking bench for mag_search_sar. A behavioural 4-bit magnitude
// comparator closes the loop (a = target, b = guess), with optional fault
// injection: an illegal code on the 2nd compare, or a comparator that always
// answers "a > b". Expected guess sequences and outcomes are queued before a
// search is launched and popped as the DUT produces them.
module tb_mag_search_sar;
  import mag_pkg::*;

  localparam int WIDTH  = 4;
  localparam int STEP_W = $clog2(WIDTH + 2);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        cmp_f;
  logic [WIDTH-1:0]  guess;
  logic              busy;
  logic              done;
  logic              found;
  logic              err;
  logic [WIDTH-1:0]  result;
  logic [STEP_W-1:0] steps;

  mag_search_sar #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_f  (cmp_f),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
    .result (result),
    .steps  (steps)
  );

  always #5 clk = ~clk;

  // Comparator model plus fault injection.
  // force_mode: 0 honest, 1 illegal code on 2nd compare, 2 always a>b.
  logic [WIDTH-1:0] target;
  int               force_mode;
  int               cmp_idx;

  always @(posedge clk) begin
    if (rst)                        cmp_idx <= 0;
    else if (start && !busy && !done) cmp_idx <= 0;
    else if (busy)                  cmp_idx <= cmp_idx + 1;
  end

  always_comb begin
    if (force_mode == 1 && cmp_idx == 1)  cmp_f = CMP_BAD;
    else if (force_mode == 2)             cmp_f = CMP_GT;
    else if (target == guess)             cmp_f = CMP_EQ;
    else if (target < guess)              cmp_f = CMP_LT;
    else                                  cmp_f = CMP_GT;
  end

  // Scoreboard.
  typedef struct {
    string tag;
    int    found;
    int    err;
    int    result;
    int    steps;
  } exp_t;

  exp_t exp_q[$];
  int   exp_guess_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check_output(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, expv);
    end
  endtask

  task automatic push_guesses(input int g0, input int g1, input int g2,
                              input int g3, input int g4);
    exp_guess_q.delete();
    if (g0 >= 0) exp_guess_q.push_back(g0);
    if (g1 >= 0) exp_guess_q.push_back(g1);
    if (g2 >= 0) exp_guess_q.push_back(g2);
    if (g3 >= 0) exp_guess_q.push_back(g3);
    if (g4 >= 0) exp_guess_q.push_back(g4);
  endtask

  // Launches one search and follows it to its done pulse. restart_at > 0
  // pulses start again after that many guesses have been seen in SEARCH.
  task automatic apply_stimulus(input string tag, input int tgt, input int fmode,
                                input int e_found, input int e_err,
                                input int e_result, input int e_steps,
                                input int restart_at);
    exp_t e;
    int   n;
    int   edges;
    int   last_guess;
    bit   finished;
    exp_q.push_back('{tag, e_found, e_err, e_result, e_steps});
    target     = WIDTH'(tgt);
    force_mode = fmode;
    last_guess = -1;
    n          = 0;
    finished   = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
      if (busy) begin
        if (exp_guess_q.size() > 0) begin
          last_guess = exp_guess_q.pop_front();
          check_output({tag, " guess"}, int'(guess), last_guess);
        end else begin
          check_output({tag, " extra guess"}, int'(guess), -1);
        end
        n++;
        if (n == restart_at) start = 1'b1;
      end else if (done) begin
        e = exp_q.pop_front();
        check_output({e.tag, " found"}, int'(found), e.found);
        check_output({e.tag, " err"}, int'(err), e.err);
        if (e.found == 1) check_output({e.tag, " result"}, int'(result), e.result);
        check_output({e.tag, " steps"}, int'(steps), e.steps);
        check_output({e.tag, " guesses left"}, exp_guess_q.size(), 0);
        check_output({e.tag, " latency"}, edges + 1, e.steps + 2);
        finished = 1'b1;
      end else begin
        check_output({tag, " idle while searching"}, 0, 1);
      end
      if (!finished) begin
        @(negedge clk);
        start = 1'b0;
        edges++;
      end
    end
    if (!finished) begin
      check_output({tag, " timeout"}, 0, 1);
      exp_q.delete();
    end else begin
      @(negedge clk);
      check_output({tag, " done pulse once"}, int'(done), 0);
      check_output({tag, " guess hold"}, int'(guess), last_guess);
      check_output({tag, " steps hold"}, int'(steps), e_steps);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    target     = '0;
    force_mode = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_output("reset guess",  int'(guess),  0);
    check_output("reset busy",   int'(busy),   0);
    check_output("reset done",   int'(done),   0);
    check_output("reset found",  int'(found),  0);
    check_output("reset err",    int'(err),    0);
    check_output("reset result", int'(result), 0);
    check_output("reset steps",  int'(steps),  0);

    $display("[TB] target 8");
    push_guesses(7, 11, 9, 8, -1);
    apply_stimulus("t8", 8, 0, 1, 0, 8, 4, 0);

    $display("[TB] target 0");
    push_guesses(7, 3, 1, 0, -1);
    apply_stimulus("t0", 0, 0, 1, 0, 0, 4, 0);

    $display("[TB] target 15");
    push_guesses(7, 11, 13, 14, 15);
    apply_stimulus("t15", 15, 0, 1, 0, 15, 5, 0);

    $display("[TB] illegal code on second compare");
    push_guesses(7, 11, -1, -1, -1);
    apply_stimulus("bad", 8, 1, 0, 1, 0, 2, 0);

    $display("[TB] lying comparator");
    push_guesses(7, 11, 13, 14, 15);
    apply_stimulus("lie", 3, 2, 0, 0, 0, 5, 0);

    $display("[TB] start during search");
    push_guesses(7, 11, 9, 8, -1);
    apply_stimulus("restart", 8, 0, 1, 0, 8, 4, 2);

    $display("[TB] reset mid-search");
    target     = WIDTH'(9);
    force_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("mid busy", int'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("mid rst guess",  int'(guess),  0);
    check_output("mid rst busy",   int'(busy),   0);
    check_output("mid rst done",   int'(done),   0);
    check_output("mid rst found",  int'(found),  0);
    check_output("mid rst err",    int'(err),    0);
    check_output("mid rst result", int'(result), 0);
    check_output("mid rst steps",  int'(steps),  0);

    push_guesses(7, 3, 5, -1, -1);
    apply_stimulus("t5", 5, 0, 1, 0, 5, 3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
